inst_cache_2w: RTL and testbench



---
 rtl/inst_cache_2w_if.sv | 25 ++
 rtl/inst_cache_2w.sv | 128 ++++++++++++
 tb/tb_inst_cache_2w.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_cache_2w_if.sv
// Signal bundle between the fetch stage, inst_cache_2w and the backing
// instruction memory. The cache side uses the slave modport.
interface inst_cache_2w_if;
  logic        InstMem_Read;
  logic [31:0] inst_address;
  logic [31:0] inst1_in;
  logic [31:0] inst2_in;
  logic        InstMem_Ready;
  logic        flush;
  logic        mem_read;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [31:0] miss_count;

  modport slave (
    input  InstMem_Read, inst_address, flush, mem_data, mem_ready,
    output inst1_in, inst2_in, InstMem_Ready, mem_read, mem_address, miss_count
  );

  modport master (
    output InstMem_Read, inst_address, flush, mem_data, mem_ready,
    input  inst1_in, inst2_in, InstMem_Ready, mem_read, mem_address, miss_count
  );
endinterface

// File: rtl/inst_cache_2w.sv
// Direct-mapped instruction cache delivering the pair (addr, addr+4) per cycle
// on a hit, refilling 4-word lines one word at a time from backing memory.
module inst_cache_2w #(
  parameter int LINES = 16
) (
  input logic            clk,
  input logic            rst,
  inst_cache_2w_if.slave bus
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t             state_q, state_d;
  logic [1:0]         wordCnt_q, wordCnt_d;
  logic [27:0]        refillLine_q, refillLine_d;
  logic [31:0]        missCount_q, missCount_d;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q [LINES];
  logic [31:0]        data_q [LINES][4];

  logic [29:0]        wordA, wordB;
  logic [IDX_W-1:0]   idxA, idxB, refillIdx, startIdx;
  logic [TAG_W-1:0]   tagA, tagB;
  logic               hitA, hitB, ready;
  logic               startRefill, wordWe, lineDone, clearAll;
  logic [1:0]         unused_addr_bits;

  // Word B is simply the next word address, so the line/index wrap falls out naturally.
  assign wordA            = bus.inst_address[31:2];
  assign wordB            = wordA + 30'd1;
  assign unused_addr_bits = bus.inst_address[1:0];
  assign idxA             = wordA[2 +: IDX_W];
  assign idxB             = wordB[2 +: IDX_W];
  assign tagA             = wordA[29 -: TAG_W];
  assign tagB             = wordB[29 -: TAG_W];
  assign hitA             = valid_q[idxA] && (tag_q[idxA] == tagA);
  assign hitB             = valid_q[idxB] && (tag_q[idxB] == tagB);
  assign refillIdx        = refillLine_q[IDX_W-1:0];
  assign startIdx         = refillLine_d[IDX_W-1:0];

  always_comb begin
    state_d      = state_q;
    wordCnt_d    = wordCnt_q;
    refillLine_d = refillLine_q;
    missCount_d  = missCount_q;
    ready        = 1'b0;
    startRefill  = 1'b0;
    wordWe       = 1'b0;
    lineDone     = 1'b0;
    clearAll     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          clearAll = 1'b1;
        end else if (bus.InstMem_Read) begin
          if (hitA && hitB) begin
            ready = 1'b1;
          end else begin
            // A's line takes priority; B is fetched on the next pass through IDLE.
            startRefill  = 1'b1;
            refillLine_d = hitA ? wordB[29:2] : wordA[29:2];
            wordCnt_d    = 2'd0;
            state_d      = REFILL;
          end
        end
      end
      REFILL: begin
        if (bus.flush) begin
          clearAll  = 1'b1;
          wordCnt_d = 2'd0;
          state_d   = IDLE;
        end else if (bus.mem_ready) begin
          wordWe    = 1'b1;
          wordCnt_d = wordCnt_q + 2'd1;
          if (wordCnt_q == 2'd3) begin
            lineDone    = 1'b1;
            missCount_d = missCount_q + 32'd1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.InstMem_Ready = ready;
  assign bus.inst1_in      = ready ? data_q[idxA][wordA[1:0]] : 32'd0;
  assign bus.inst2_in      = ready ? data_q[idxB][wordB[1:0]] : 32'd0;
  assign bus.mem_read      = (state_q == REFILL);
  assign bus.mem_address   = (state_q == REFILL) ? {refillLine_q, wordCnt_q, 2'b00} : 32'd0;
  assign bus.miss_count    = missCount_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wordCnt_q    <= 2'd0;
      refillLine_q <= 28'd0;
      missCount_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      wordCnt_q    <= wordCnt_d;
      refillLine_q <= refillLine_d;
      missCount_q  <= missCount_d;
    end
  end

  // The target line is invalidated when a refill starts so an aborted refill leaves it unusable.
  always_ff @(posedge clk) begin
    if (rst || clearAll) begin
      valid_q <= '0;
    end else if (startRefill) begin
      valid_q[startIdx] <= 1'b0;
    end else if (lineDone) begin
      valid_q[refillIdx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wordWe) begin
      data_q[refillIdx][wordCnt_q] <= bus.mem_data;
    end
    if (lineDone) begin
      tag_q[refillIdx] <= refillLine_q[27 -: TAG_W];
    end
  end
endmodule

// File: tb/tb_inst_cache_2w.sv
// Self-checking bench for inst_cache_2w: scoreboarded fetches against a backing
// memory whose word n holds 0x1000+n, with optional wait states.
module tb_inst_cache_2w;
  logic clk = 1'b0;
  logic rst;

  inst_cache_2w_if busIf();

  inst_cache_2w #(.LINES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst1;
    logic [31:0] inst2;
    logic [31:0] misses;
    int          latency;
  } fetchExp_t;

  fetchExp_t   expQ[$];
  logic [31:0] expAddrQ[$];
  logic [31:0] obsAddrQ[$];
  int          passCount = 0;
  int          checkCount = 0;
  int          waitStates = 0;
  int          waitCnt = 0;
  int          unstableCount = 0;
  logic [31:0] heldAddr = 32'd0;

  // Backing memory: decides mem_ready on the falling edge for the next rising edge,
  // logs every accepted word address, and watches address stability during waits.
  always @(negedge clk) begin
    if (busIf.mem_read === 1'b1) begin
      if (waitCnt == 0) heldAddr = busIf.mem_address;
      else if (busIf.mem_address !== heldAddr) unstableCount++;
      busIf.mem_data = 32'h1000 + (busIf.mem_address >> 2);
      if (waitCnt >= waitStates) begin
        busIf.mem_ready = 1'b1;
        obsAddrQ.push_back(busIf.mem_address);
        waitCnt = 0;
      end else begin
        busIf.mem_ready = 1'b0;
        waitCnt++;
      end
    end else begin
      busIf.mem_ready = 1'b0;
      waitCnt = 0;
    end
  end

  // Expected pair and bookkeeping for one fetch, derived from the memory pattern.
  function automatic fetchExp_t makeExp(input logic [31:0] addr, input int lat,
                                        input logic [31:0] misses);
    fetchExp_t e;
    e.inst1   = 32'h1000 + (addr >> 2);
    e.inst2   = 32'h1000 + ((addr + 32'd4) >> 2);
    e.misses  = misses;
    e.latency = lat;
    return e;
  endfunction

  task automatic pushLine(input logic [31:0] base);
    for (int i = 0; i < 4; i++) expAddrQ.push_back(base + 32'(4 * i));
  endtask

  // Holds a fetch request until InstMem_Ready (bounded), returning what the DUT showed.
  task automatic doFetch(input logic [31:0] addr, output int lat, output logic [31:0] o1,
                         output logic [31:0] o2, output logic [31:0] mc, output logic sawRead);
    busIf.inst_address = addr;
    busIf.InstMem_Read = 1'b1;
    lat = -1;
    o1 = 32'd0;
    o2 = 32'd0;
    sawRead = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (busIf.mem_read === 1'b1) sawRead = 1'b1;
      if (busIf.InstMem_Ready === 1'b1) begin
        lat = c;
        o1 = busIf.inst1_in;
        o2 = busIf.inst2_in;
        break;
      end
    end
    mc = busIf.miss_count;
    @(posedge clk);
    #1;
    busIf.InstMem_Read = 1'b0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    busIf.InstMem_Read = 1'b0;
    busIf.flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    obsAddrQ.delete();
    expAddrQ.delete();
  endtask

  task automatic checkFetch(input string name, input int lat, input logic [31:0] o1,
                            input logic [31:0] o2, input logic [31:0] mc);
    fetchExp_t e;
    e = expQ.pop_front();
    checkCount++;
    if (lat !== e.latency) $display("FAIL %s_latency: got %0d, expected %0d", name, lat, e.latency);
    else passCount++;
    checkCount++;
    if (o1 !== e.inst1) $display("FAIL %s_inst1: got %h, expected %h", name, o1, e.inst1);
    else passCount++;
    checkCount++;
    if (o2 !== e.inst2) $display("FAIL %s_inst2: got %h, expected %h", name, o2, e.inst2);
    else passCount++;
    checkCount++;
    if (mc !== e.misses) $display("FAIL %s_miss_count: got %0d, expected %0d", name, mc, e.misses);
    else passCount++;
  endtask

  task automatic checkAddrs(input string name);
    logic [31:0] expA, obsA;
    checkCount++;
    if (obsAddrQ.size() != expAddrQ.size())
      $display("FAIL %s_word_count: got %0d, expected %0d", name, obsAddrQ.size(), expAddrQ.size());
    else passCount++;
    while (expAddrQ.size() > 0 && obsAddrQ.size() > 0) begin
      expA = expAddrQ.pop_front();
      obsA = obsAddrQ.pop_front();
      checkCount++;
      if (obsA !== expA) $display("FAIL %s_mem_address: got %h, expected %h", name, obsA, expA);
      else passCount++;
    end
    expAddrQ.delete();
    obsAddrQ.delete();
  endtask

  int          lat;
  logic [31:0] o1, o2, mc;
  logic        sawRead;

  task automatic test_reset();
    applyReset();
    @(negedge clk);
    checkCount++;
    if (busIf.InstMem_Ready !== 1'b0) $display("FAIL reset_ready: got %b, expected 0", busIf.InstMem_Ready);
    else passCount++;
    checkCount++;
    if (busIf.mem_read !== 1'b0) $display("FAIL reset_mem_read: got %b, expected 0", busIf.mem_read);
    else passCount++;
    checkCount++;
    if (busIf.mem_address !== 32'd0) $display("FAIL reset_mem_address: got %h, expected 0", busIf.mem_address);
    else passCount++;
    checkCount++;
    if (busIf.miss_count !== 32'd0) $display("FAIL reset_miss_count: got %0d, expected 0", busIf.miss_count);
    else passCount++;
    checkCount++;
    if (busIf.inst1_in !== 32'd0) $display("FAIL reset_inst1: got %h, expected 0", busIf.inst1_in);
    else passCount++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_cold_miss();
    expQ.push_back(makeExp(32'h00, 5, 32'd1));
    pushLine(32'h00);
    doFetch(32'h00, lat, o1, o2, mc, sawRead);
    checkFetch("cold", lat, o1, o2, mc);
    checkAddrs("cold");
  endtask

  task automatic test_hit();
    expQ.push_back(makeExp(32'h08, 0, 32'd1));
    doFetch(32'h08, lat, o1, o2, mc, sawRead);
    checkFetch("hit", lat, o1, o2, mc);
    checkCount++;
    if (sawRead !== 1'b0) $display("FAIL hit_mem_read: got %b, expected 0", sawRead);
    else passCount++;
  endtask

  task automatic test_double_miss();
    applyReset();
    expQ.push_back(makeExp(32'h1C, 10, 32'd2));
    pushLine(32'h10);
    pushLine(32'h20);
    doFetch(32'h1C, lat, o1, o2, mc, sawRead);
    checkFetch("straddle", lat, o1, o2, mc);
    checkAddrs("straddle");
  endtask

  // Last word of line 15 pairs with index 0 under the next tag; 0x00 then evicts it back.
  task automatic test_wrap();
    expQ.push_back(makeExp(32'hFC, 10, 32'd4));
    pushLine(32'hF0);
    pushLine(32'h100);
    doFetch(32'hFC, lat, o1, o2, mc, sawRead);
    checkFetch("wrap", lat, o1, o2, mc);
    checkAddrs("wrap");
    expQ.push_back(makeExp(32'h100, 0, 32'd4));
    doFetch(32'h100, lat, o1, o2, mc, sawRead);
    checkFetch("wrap_hit", lat, o1, o2, mc);
    expQ.push_back(makeExp(32'h00, 5, 32'd5));
    pushLine(32'h00);
    doFetch(32'h00, lat, o1, o2, mc, sawRead);
    checkFetch("wrap_evict", lat, o1, o2, mc);
    checkAddrs("wrap_evict");
  endtask

  task automatic test_wait_states();
    waitStates = 2;
    unstableCount = 0;
    expQ.push_back(makeExp(32'h40, 13, 32'd6));
    pushLine(32'h40);
    doFetch(32'h40, lat, o1, o2, mc, sawRead);
    checkFetch("wait", lat, o1, o2, mc);
    checkAddrs("wait");
    checkCount++;
    if (unstableCount != 0) $display("FAIL wait_addr_stable: got %0d changes, expected 0", unstableCount);
    else passCount++;
    waitStates = 0;
  endtask

  // Flush while word 2 is on the bus, then flush while idle on a valid line.
  task automatic test_flush();
    busIf.inst_address = 32'h80;
    busIf.InstMem_Read = 1'b1;
    @(posedge clk); #1;
    busIf.InstMem_Read = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    busIf.flush = 1'b1;
    @(posedge clk); #1;
    busIf.flush = 1'b0;
    @(negedge clk);
    checkCount++;
    if (busIf.mem_read !== 1'b0) $display("FAIL flush_abort_mem_read: got %b, expected 0", busIf.mem_read);
    else passCount++;
    checkCount++;
    if (busIf.miss_count !== 32'd6) $display("FAIL flush_abort_miss_count: got %0d, expected 6", busIf.miss_count);
    else passCount++;
    @(posedge clk); #1;
    obsAddrQ.delete();
    expQ.push_back(makeExp(32'h80, 5, 32'd7));
    pushLine(32'h80);
    doFetch(32'h80, lat, o1, o2, mc, sawRead);
    checkFetch("flush_refetch", lat, o1, o2, mc);
    checkAddrs("flush_refetch");
    busIf.inst_address = 32'h80;
    busIf.InstMem_Read = 1'b1;
    busIf.flush = 1'b1;
    @(negedge clk);
    checkCount++;
    if (busIf.InstMem_Ready !== 1'b0) $display("FAIL flush_idle_ready: got %b, expected 0", busIf.InstMem_Ready);
    else passCount++;
    @(posedge clk); #1;
    busIf.flush = 1'b0;
    busIf.InstMem_Read = 1'b0;
    expQ.push_back(makeExp(32'h80, 5, 32'd8));
    pushLine(32'h80);
    doFetch(32'h80, lat, o1, o2, mc, sawRead);
    checkFetch("flush_idle_refetch", lat, o1, o2, mc);
    checkAddrs("flush_idle_refetch");
  endtask

  task automatic test_reset_refill();
    busIf.inst_address = 32'hC0;
    busIf.InstMem_Read = 1'b1;
    @(posedge clk); #1;
    busIf.InstMem_Read = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkCount++;
    if (busIf.mem_read !== 1'b0) $display("FAIL rst_abort_mem_read: got %b, expected 0", busIf.mem_read);
    else passCount++;
    checkCount++;
    if (busIf.mem_address !== 32'd0) $display("FAIL rst_abort_mem_address: got %h, expected 0", busIf.mem_address);
    else passCount++;
    checkCount++;
    if (busIf.miss_count !== 32'd0) $display("FAIL rst_abort_miss_count: got %0d, expected 0", busIf.miss_count);
    else passCount++;
    @(posedge clk); #1;
    obsAddrQ.delete();
    expQ.push_back(makeExp(32'hC0, 5, 32'd1));
    pushLine(32'hC0);
    doFetch(32'hC0, lat, o1, o2, mc, sawRead);
    checkFetch("rst_refetch", lat, o1, o2, mc);
    checkAddrs("rst_refetch");
  endtask

  initial begin
    rst = 1'b1;
    busIf.InstMem_Read = 1'b0;
    busIf.inst_address = 32'd0;
    busIf.flush = 1'b0;
    busIf.mem_data = 32'd0;
    busIf.mem_ready = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_double_miss();
    test_wrap();
    test_wait_states();
    test_flush();
    test_reset_refill();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
